bch_bm_iter: RTL and testbench
==============================

Name: bch_bm_iter

Overview:
- Parametrised, iterative, inversionless Berlekamp-Massey engine for binary BCH decoding over GF(2^M).
- Successor to the fixed t=2, GF(16) key-equation block: generalised in field size and correction capability T, with a start/busy/done handshake and a failure flag.
- Sits between the syndrome calculator and the Chien search.
- Takes odd-indexed-up-to-(2T-1) syndromes and produces a (scaled) error-locator polynomial Λ(x) and its degree L.

Parameters:
- M, 4, field degree; symbols are M bits.
- T, 2, correctable errors; T ≥ 1.
- PRIM_POLY, 5'b10011, primitive polynomial, M+1 bits (x^4+x+1).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled on the rising edge.
- syn  input  (2T-1)*M  syndromes S1..S(2T-1); S1 in bits [M-1:0], Sj in bits [jM-1:(j-1)M].
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse; lambda/lambda_deg/fail valid.
- lambda  output  (T+1)*M  Λ0..ΛT; Λ0 in bits [M-1:0].
- lambda_deg  output  $clog2(T+1)  final L.
- fail  output  1  uncorrectable indication.

Behaviour:
- Reset (rst=0, async): state IDLE; busy=0, done=0, lambda=0, lambda_deg=0, fail=0; all internal registers cleared.
- FSM states: IDLE, ITER, DONE.
  - IDLE→ITER on start=1.
  - ITER→DONE after iteration r=T-1 commits.
  - DONE→ITER if start=1, else DONE→IDLE.
  - start in ITER is ignored; the in-flight computation is unaffected.
- Load edge (start accepted at edge k): capture syn into an internal register, then set Λ=1, B=1, L=0, γ=1, r=0. Later syn changes have no effect.
- Iteration: edges k+1..k+T each perform one simplified binary iteration r = 0..T-1.
  - δ = Σ_{i=0..min(2r,T)} Λi·S(2r+1-i).
  - Λ' = γ·Λ + δ·x·B, truncated to degree T.
  - If δ≠0 and 2L ≤ 2r: B' = x·Λ(old), L' = 2r+1-L, γ' = δ.
  - Otherwise: B' = x²·B, with L and γ unchanged.
  - B is truncated to degree T.
- Arithmetic: GF(2^M) polynomial-basis multiply modulo PRIM_POLY; addition is XOR. No inversion anywhere.
- Output timing: lambda, lambda_deg and fail are registered at edge k+T.
  - done=1 for exactly the cycle following edge k+T, i.e. latency T cycles from start edge to done.
  - busy=1 from after edge k through edge k+T.
- Output hold: outputs hold their values until the next completion or reset.
- Output scaling: Λ is scaled by a nonzero constant (Λ0 ≠ 1 in general). Downstream normalisation is not this block's job.
- fail: fail=1 iff the coefficient Λ_L of the final Λ is zero. All-zero syndromes give Λ=1, L=0, fail=0.
- Back-to-back: a start in the DONE cycle is accepted; syn is reloaded at that edge and done drops.
- Reset mid-operation: everything aborts immediately, no done is produced, and all outputs return to 0.

Test Plan:
1. Two errors, M=4, T=2, syn={S3=0110, S2=0101, S1=0011}, start at edge k.
   - done high after edge k+2.
   - lambda = Λ0 0011, Λ1 0101, Λ2 1001; lambda_deg=2; fail=0.
   - Normalised form is 1, 0011, 0111.
2. Single error, S1=1000, S2=1100, S3=1010.
   - lambda = Λ0 1000, Λ1 1100, Λ2 0000; lambda_deg=1; fail=0.
3. All-zero syndromes.
   - lambda = 0001, 0000, 0000; lambda_deg=0; fail=0; latency 2.
4. Reset during ITER: assert rst one cycle after start.
   - Outputs are 0 immediately; no done pulse.
   - A fresh start with the case-1 syndromes completes with the case-1 results.
5. Handshake corner cases:
   - start pulsed during busy with different syn: ignored; case-1 result unchanged.
   - start with case-2 syndromes held in the done cycle: accepted; case-2 result 2 cycles later.
6. T=3, M=4, syn S1..S5 = 0011, 0101, 0110, 0010, 0111.
   - done after 3 cycles.
   - lambda = 1000, 1011, 1101, 0000; lambda_deg=2; fail=0.

Source files
------------

// File: rtl/bch_bm_iter.sv
// Iterative inversionless Berlekamp-Massey engine for binary BCH codes over GF(2^M).
// It takes syndromes S1..S(2T-1) and returns a scaled error-locator polynomial and its degree.
// The result comes T cycles after the start edge that loads the syndromes.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   start      load syndromes and begin; ignored while iterating
//   syn        S1..S(2T-1), S1 in the least significant M bits
//   busy       high while iterations are in flight
//   done       one-cycle pulse; lambda/lambda_deg/fail are valid
//   lambda     Lambda_0..Lambda_T, Lambda_0 in the least significant M bits
//   lambda_deg final register length L
//   fail       the final Lambda_L coefficient is zero (uncorrectable)
module bch_bm_iter #(
    parameter int unsigned M         = 4,
    parameter int unsigned T         = 2,
    parameter logic [M:0]  PRIM_POLY = 5'b10011
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [(2*T-1)*M-1:0]                syn,
    output logic                                busy,
    output logic                                done,
    output logic [(T+1)*M-1:0]                  lambda,
    output logic [$clog2(T+1)-1:0]              lambda_deg,
    output logic                                fail
);

    localparam int unsigned NS   = 2 * T - 1;
    localparam int unsigned SW   = NS * M;
    localparam int unsigned LDW  = $clog2(T + 1);
    // Internal L can reach 2T-1 before the fail check.
    localparam int unsigned LW   = $clog2(2 * T);
    localparam int unsigned RW   = (T > 1) ? $clog2(T) : 1;
    localparam logic [M-1:0] POLY_LO = PRIM_POLY[M-1:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            load_c;
    logic            iter_c;
    logic            last_c;

    logic [SW-1:0]   syn_q;
    logic [M-1:0]    lam      [T+1];
    logic [M-1:0]    b        [T+1];
    logic [LW-1:0]   l;
    logic [M-1:0]    gam;
    logic [RW-1:0]   r;

    logic [M-1:0]    lam_nxt  [T+1];
    logic [M-1:0]    b_nxt    [T+1];
    logic [LW-1:0]   l_nxt;
    logic [M-1:0]    gam_nxt;
    logic [M-1:0]    delta;
    logic [M-1:0]    sel;
    logic            upd_c;
    logic            fail_c;
    int              r_i;

    // GF(2^M) polynomial-basis multiply, shift-and-add with modular reduction.
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] bb);
        logic [M-1:0] acc;
        logic [M-1:0] sh;
        acc = '0;
        sh  = a;
        for (int k = 0; k < int'(M); k++) begin
            if (bb[k]) acc = acc ^ sh;
            sh = {sh[M-2:0], 1'b0} ^ (sh[M-1] ? POLY_LO : '0);
        end
        return acc;
    endfunction

    assign r_i    = int'(r);
    assign last_c = (r == RW'(T - 1));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next state and datapath controls.
    always_comb begin
        state_d = state_q;
        load_c  = 1'b0;
        iter_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load_c  = 1'b1;
                    state_d = ITER;
                end
            end
            ITER: begin
                iter_c = 1'b1;
                if (last_c) state_d = DONE;
            end
            DONE: begin
                if (start) begin
                    load_c  = 1'b1;
                    state_d = ITER;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Discrepancy: sum of Lambda_i * S(2r+1-i) for i <= min(2r, T).
    always_comb begin
        delta = '0;
        sel   = '0;
        for (int i = 0; i <= int'(T); i++) begin
            sel = '0;
            for (int j = 0; j < int'(NS); j++) begin
                if (j == 2 * r_i - i) sel = syn_q[j*M +: M];
            end
            if (i <= 2 * r_i) delta = delta ^ gf_mul(lam[i], sel);
        end
    end

    // One inversionless iteration; Lambda and B are truncated to degree T.
    always_comb begin
        upd_c = (delta != '0) && (int'(l) <= r_i);

        lam_nxt[0] = gf_mul(gam, lam[0]);
        for (int i = 1; i <= int'(T); i++) begin
            lam_nxt[i] = gf_mul(gam, lam[i]) ^ gf_mul(delta, b[i-1]);
        end

        // B' = x*Lambda on a length change, otherwise x^2*B.
        b_nxt[0] = '0;
        b_nxt[1] = upd_c ? lam[0] : '0;
        for (int i = 2; i <= int'(T); i++) begin
            b_nxt[i] = upd_c ? lam[i-1] : b[i-2];
        end

        l_nxt   = upd_c ? LW'(2 * r_i + 1 - int'(l)) : l;
        gam_nxt = upd_c ? delta : gam;

        // A length beyond T has no stored coefficient, so it counts as zero.
        fail_c = 1'b1;
        for (int i = 0; i <= int'(T); i++) begin
            if (int'(l_nxt) == i) fail_c = (lam_nxt[i] == '0);
        end
    end

    // Working registers: load on an accepted start, otherwise step while iterating.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            syn_q <= '0;
            for (int i = 0; i <= int'(T); i++) begin
                lam[i] <= '0;
                b[i]   <= '0;
            end
            l   <= '0;
            gam <= '0;
            r   <= '0;
        end else if (load_c) begin
            syn_q <= syn;
            for (int i = 0; i <= int'(T); i++) begin
                lam[i] <= (i == 0) ? M'(1) : '0;
                b[i]   <= (i == 0) ? M'(1) : '0;
            end
            l   <= '0;
            gam <= M'(1);
            r   <= '0;
        end else if (iter_c) begin
            for (int i = 0; i <= int'(T); i++) begin
                lam[i] <= lam_nxt[i];
                b[i]   <= b_nxt[i];
            end
            l   <= l_nxt;
            gam <= gam_nxt;
            r   <= r + RW'(1);
        end
    end

    // Registered handshake and result outputs; results are held until the next completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            lambda     <= '0;
            lambda_deg <= '0;
            fail       <= 1'b0;
        end else begin
            busy <= (state_d == ITER);
            done <= (state_d == DONE);
            if (iter_c && last_c) begin
                for (int i = 0; i <= int'(T); i++) begin
                    lambda[i*M +: M] <= lam_nxt[i];
                end
                lambda_deg <= LDW'(l_nxt);
                fail       <= fail_c;
            end
        end
    end

endmodule

// File: tb/tb_bch_bm_iter.sv
// Directed bench for bch_bm_iter: a GF(16) T=2 instance driven from a vector table plus
// handshake/reset sequences, and a T=3 instance for the larger configuration.
module tb_bch_bm_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start2;
    logic [11:0] syn2;
    logic        busy2;
    logic        done2;
    logic [11:0] lam2;
    logic [1:0]  deg2;
    logic        fail2;

    logic        start3;
    logic [19:0] syn3;
    logic        busy3;
    logic        done3;
    logic [15:0] lam3;
    logic [1:0]  deg3;
    logic        fail3;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string       name;
        logic [11:0] syn;
        logic [11:0] lam;
        logic [1:0]  deg;
        logic        fail;
    } vec_t;

    vec_t vt[5];

    always #5 clk = ~clk;

    bch_bm_iter #(.M(4), .T(2), .PRIM_POLY(5'b10011)) u2 (
        .clk(clk), .rst(rst), .start(start2), .syn(syn2),
        .busy(busy2), .done(done2), .lambda(lam2), .lambda_deg(deg2), .fail(fail2)
    );

    bch_bm_iter #(.M(4), .T(3), .PRIM_POLY(5'b10011)) u3 (
        .clk(clk), .rst(rst), .start(start3), .syn(syn3),
        .busy(busy3), .done(done3), .lambda(lam3), .lambda_deg(deg3), .fail(fail3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Present start for one edge, then scramble syn to prove it was captured.
    task automatic launch2(input logic [11:0] s);
        syn2   = s;
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        syn2   = 12'($urandom);
    endtask

    task automatic wait_done2(output int lat);
        lat = 0;
        while (done2 !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int ndone;

        vt[0] = '{"two_err",  12'h653, 12'h953, 2'd2, 1'b0};
        vt[1] = '{"one_err",  12'hAC8, 12'h0C8, 2'd1, 1'b0};
        vt[2] = '{"zero_syn", 12'h000, 12'h001, 2'd0, 1'b0};
        vt[3] = '{"one_err_a",12'h842, 12'h042, 2'd1, 1'b0};
        vt[4] = '{"uncorr",   12'h100, 12'h001, 2'd3, 1'b1};

        rst    = 1'b0;
        start2 = 1'b0;
        start3 = 1'b0;
        syn2   = '0;
        syn3   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset lambda", 32'(lam2), 32'h0);
        chk("reset deg",    32'(deg2), 32'h0);
        chk("reset fail",   32'(fail2), 32'h0);
        chk("reset busy",   32'(busy2), 32'h0);
        chk("reset done",   32'(done2), 32'h0);
        chk("reset lambda t3", 32'(lam3), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vt[v]) begin
            @(negedge clk);
            launch2(vt[v].syn);
            chk({vt[v].name, " busy"}, 32'(busy2), 32'h1);
            wait_done2(lat);
            chk({vt[v].name, " latency"}, 32'(lat), 32'd2);
            chk({vt[v].name, " lambda"}, 32'(lam2), 32'(vt[v].lam));
            chk({vt[v].name, " deg"}, 32'(deg2), 32'(vt[v].deg));
            chk({vt[v].name, " fail"}, 32'(fail2), 32'(vt[v].fail));
            chk({vt[v].name, " busy at done"}, 32'(busy2), 32'h0);
            @(posedge clk);
            #1;
            chk({vt[v].name, " done pulse"}, 32'(done2), 32'h0);
            chk({vt[v].name, " lambda hold"}, 32'(lam2), 32'(vt[v].lam));
        end

        // start while iterating, with other syndromes, must be ignored
        @(negedge clk);
        launch2(12'h653);
        @(negedge clk);
        syn2   = 12'hAC8;
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        wait_done2(lat);
        chk("busy start latency", 32'(lat), 32'd1);
        chk("busy start lambda", 32'(lam2), 32'h953);
        chk("busy start deg", 32'(deg2), 32'd2);

        // back-to-back start in the done cycle
        launch2(12'hAC8);
        chk("b2b done drop", 32'(done2), 32'h0);
        chk("b2b busy", 32'(busy2), 32'h1);
        wait_done2(lat);
        chk("b2b latency", 32'(lat), 32'd2);
        chk("b2b lambda", 32'(lam2), 32'h0C8);
        chk("b2b deg", 32'(deg2), 32'd1);

        // reset in the middle of an iteration
        @(negedge clk);
        launch2(12'h653);
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst lambda", 32'(lam2), 32'h0);
        chk("midrst deg", 32'(deg2), 32'h0);
        chk("midrst fail", 32'(fail2), 32'h0);
        chk("midrst busy", 32'(busy2), 32'h0);
        ndone = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (done2 === 1'b1) ndone++;
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (done2 === 1'b1) ndone++;
        end
        chk("midrst no done", 32'(ndone), 32'd0);
        chk("midrst idle", 32'(busy2), 32'h0);
        @(negedge clk);
        launch2(12'h653);
        wait_done2(lat);
        chk("after rst latency", 32'(lat), 32'd2);
        chk("after rst lambda", 32'(lam2), 32'h953);
        chk("after rst deg", 32'(deg2), 32'd2);
        chk("after rst fail", 32'(fail2), 32'h0);

        // T=3 instance
        @(negedge clk);
        syn3   = 20'h72653;
        start3 = 1'b1;
        @(posedge clk);
        #1;
        start3 = 1'b0;
        syn3   = 20'($urandom);
        chk("t3 busy", 32'(busy3), 32'h1);
        lat = 0;
        while (done3 !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("t3 latency", 32'(lat), 32'd3);
        chk("t3 lambda", 32'(lam3), 32'h0DB8);
        chk("t3 deg", 32'(deg3), 32'd2);
        chk("t3 fail", 32'(fail3), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
